pmem_bridge: RTL and testbench



---
 rtl/pmem_bridge_pkg.sv | 11 +
 rtl/wb_entry.sv | 35 +++
 rtl/pmem_bridge.sv | 142 ++++++++++++++
 tb/tb_pmem_bridge.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_bridge_pkg.sv
// Shared line geometry for the L2-to-physical-memory path.
// The line tag is addr[31:OFFSET_BITS]; everything below it selects a byte within the line.
package pmem_bridge_pkg;

    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;
    localparam int TAG_W       = 32 - OFFSET_BITS;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/wb_entry.sv
// One-entry write-back buffer: a captured L2 eviction line plus its tag.
// hit is combinational so the bridge can serve a read from it in the sampling cycle.
module wb_entry
    import pmem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic [LINE_W-1:0] load_data,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              valid,
    output logic [TAG_W-1:0]  tag,
    output logic [LINE_W-1:0] data,
    output logic              hit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= load_tag;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/pmem_bridge.sv
// Registered request/response stage between the L2 memory-side port and physical memory,
// with a one-entry write-back buffer drained to pmem whenever the L2 side is quiet.
module pmem_bridge
    import pmem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RD_PMEM, DRAIN, RESP} state_t;

    // Handshake: the L2 holds mem_read/mem_write and its address/data stable until it sees the
    // one-cycle mem_resp pulse; toward pmem we hold pmem_read/pmem_write stable until pmem_resp.
    state_t             state, state_n;
    logic               pmem_read_n, pmem_write_n, mem_resp_n;
    logic [31:0]        pmem_address_n;
    logic [LINE_W-1:0]  pmem_wdata_n, mem_rdata_n;
    logic               start_drain;
    logic               buf_load, buf_clear, buf_valid, buf_hit;
    logic [TAG_W-1:0]   buf_tag;
    logic [LINE_W-1:0]  buf_data;

    // Offset bits never matter: pmem is addressed by whole lines.
    logic unused_offset_bits;
    assign unused_offset_bits = ^mem_addr[OFFSET_BITS-1:0];

    wb_entry u_wb_entry (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_tag   (mem_addr[31:OFFSET_BITS]),
        .load_data  (mem_wdata),
        .lookup_tag (mem_addr[31:OFFSET_BITS]),
        .valid      (buf_valid),
        .tag        (buf_tag),
        .data       (buf_data),
        .hit        (buf_hit)
    );

    always_comb begin
        state_n        = state;
        pmem_read_n    = pmem_read;
        pmem_write_n   = pmem_write;
        pmem_address_n = pmem_address;
        pmem_wdata_n   = pmem_wdata;
        mem_rdata_n    = mem_rdata;
        mem_resp_n     = 1'b0;
        buf_load       = 1'b0;
        buf_clear      = 1'b0;
        start_drain    = 1'b0;

        case (state)
            IDLE: begin
                // A simultaneous read+write is treated as a write.
                if (mem_write) begin
                    if (!buf_valid) begin
                        buf_load   = 1'b1;
                        mem_resp_n = 1'b1;
                        state_n    = RESP;
                    end else begin
                        start_drain = 1'b1;
                    end
                end else if (mem_read && buf_hit) begin
                    mem_rdata_n = buf_data;
                    mem_resp_n  = 1'b1;
                    state_n     = RESP;
                end else if (mem_read) begin
                    pmem_read_n    = 1'b1;
                    pmem_address_n = {mem_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    state_n        = RD_PMEM;
                end else if (buf_valid) begin
                    start_drain = 1'b1;
                end
            end
            RD_PMEM: begin
                if (pmem_resp) begin
                    mem_rdata_n = pmem_rdata;
                    pmem_read_n = 1'b0;
                    mem_resp_n  = 1'b1;
                    state_n     = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    pmem_write_n = 1'b0;
                    buf_clear    = 1'b1;
                    state_n      = IDLE;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (start_drain) begin
            pmem_write_n   = 1'b1;
            pmem_address_n = {buf_tag, {OFFSET_BITS{1'b0}}};
            pmem_wdata_n   = buf_data;
            state_n        = DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            mem_rdata    <= '0;
            mem_resp     <= 1'b0;
        end else begin
            state        <= state_n;
            pmem_read    <= pmem_read_n;
            pmem_write   <= pmem_write_n;
            pmem_address <= pmem_address_n;
            pmem_wdata   <= pmem_wdata_n;
            mem_rdata    <= mem_rdata_n;
            mem_resp     <= mem_resp_n;
        end
    end

    assign busy = (state != IDLE) || buf_valid;

endmodule

// File: tb/tb_pmem_bridge.sv
// Bench for pmem_bridge: directed scenarios with literal expectations, then random traffic
// checked against a line-level memory model (last value written per line tag).
module tb_pmem_bridge;
    import pmem_bridge_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_read, mem_write;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic              mem_resp;
    logic              pmem_read, pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
    logic              pmem_resp, pm_resp_auto, pm_resp_inject;
    logic              busy;

    assign pmem_resp = pm_resp_auto | pm_resp_inject;

    pmem_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .busy         (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    line_t golden[int];          // latest line the L2 wrote, per tag
    line_t pm_mem[int];          // contents of the modelled physical memory
    bit    pending[int];         // lines acknowledged to L2 but not yet in pmem
    int    fixed_delay = 0;
    int    n_pread = 0, n_pwrite = 0;
    int    pread_rise_cyc = 0, mresp_cyc = 0, presp_cyc = 0;
    logic [31:0] last_pr_addr, last_pw_addr;
    line_t       last_pw_data;
    bit          ev_wr[$];
    logic [31:0] ev_addr[$];

    function automatic line_t init_line(input int t);
        return {8{(t * 32'h9E37_79B1) ^ 32'h5A5A_0000}};
    endfunction

    function automatic line_t pm_get(input int t);
        if (pm_mem.exists(t)) return pm_mem[t];
        return init_line(t);
    endfunction

    function automatic line_t golden_get(input int t);
        if (golden.exists(t)) return golden[t];
        return init_line(t);
    endfunction

    function automatic int tag_of(input logic [31:0] a);
        return int'(a[31:OFFSET_BITS]);
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_line(input string name, input line_t act, input line_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- pmem responder ----------------
    initial begin : pmem_model
        int cnt;
        int dly;
        int t;
        cnt = 0;
        dly = 1;
        pm_resp_auto = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pm_resp_auto = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (pmem_read || pmem_write) begin
                if (cnt == 0) dly = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
                cnt++;
                if (cnt >= dly) begin
                    t = tag_of(pmem_address);
                    if (pmem_write) begin
                        chk_line("drain_data", pmem_wdata, golden_get(t));
                        chk("drain_was_pending", 32'(pending.exists(t)), 32'd1);
                        pm_mem[t] = pmem_wdata;
                        pending.delete(t);
                    end else begin
                        pmem_rdata = pm_get(t);
                    end
                    pm_resp_auto = 1'b1;
                    presp_cyc = cyc;
                    cnt = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        logic        p_pr, p_pw, p_mresp, p_presp;
        logic [31:0] p_addr;
        line_t       p_wdata, p_rdata;
        int          t;
        p_pr = 0; p_pw = 0; p_mresp = 0; p_presp = 0;
        p_addr = '0; p_wdata = '0; p_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_pr = 0; p_pw = 0; p_mresp = 0; p_presp = 0;
                p_addr = '0; p_wdata = '0; p_rdata = '0;
            end else begin
                chk("rd_wr_exclusive", 32'(pmem_read & pmem_write), 32'd0);
                if (pmem_read || pmem_write)
                    chk("pmem_addr_aligned", 32'(pmem_address[OFFSET_BITS-1:0]), 32'd0);
                if (p_pr && !p_presp) begin
                    chk("pread_held", 32'(pmem_read), 32'd1);
                    chk("pread_addr_held", pmem_address, p_addr);
                end
                if (p_pw && !p_presp) begin
                    chk("pwrite_held", 32'(pmem_write), 32'd1);
                    chk("pwrite_addr_held", pmem_address, p_addr);
                    chk_line("pwrite_data_held", pmem_wdata, p_wdata);
                end
                if (p_mresp) chk("mem_resp_one_cycle", 32'(mem_resp), 32'd0);
                if (!mem_resp) chk_line("rdata_holds", mem_rdata, p_rdata);
                chk("busy", 32'(busy),
                    32'(pmem_read | pmem_write | mem_resp | (pending.num() > 0)));

                if (pmem_read && !p_pr) begin
                    n_pread++;
                    pread_rise_cyc = cyc;
                    last_pr_addr = pmem_address;
                    ev_wr.push_back(1'b0);
                    ev_addr.push_back(pmem_address);
                    chk("read_of_buffered_line", 32'(pending.exists(tag_of(pmem_address))), 32'd0);
                    chk("pread_for_read_req", 32'(mem_read & ~mem_write), 32'd1);
                end
                if (pmem_write && !p_pw) begin
                    n_pwrite++;
                    last_pw_addr = pmem_address;
                    last_pw_data = pmem_wdata;
                    ev_wr.push_back(1'b1);
                    ev_addr.push_back(pmem_address);
                end
                if (mem_resp) begin
                    mresp_cyc = cyc;
                    t = tag_of(mem_addr);
                    chk("resp_has_request", 32'(mem_read | mem_write), 32'd1);
                    if (mem_write) begin
                        chk("single_buffered_line", 32'(pending.num()), 32'd0);
                        golden[t] = mem_wdata;
                        pending[t] = 1'b1;
                    end else begin
                        chk_line("read_data", mem_rdata, golden_get(t));
                    end
                end

                p_pr = pmem_read; p_pw = pmem_write; p_mresp = mem_resp;
                p_presp = pmem_resp; p_addr = pmem_address;
                p_wdata = pmem_wdata; p_rdata = mem_rdata;
            end
        end
    end

    // ---------------- driver tasks (entered at posedge + 1) ----------------
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input line_t d,
                          output line_t rdata, output int lat);
        int  start;
        bit  got;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        start = cyc;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (mem_resp) got = 1;
        end
        chk("request_completes", 32'(got), 32'd1);
        lat = cyc - start;
        rdata = mem_rdata;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wait_quiet(output int fall_cyc);
        bit quiet;
        quiet = 0;
        fall_cyc = 0;
        for (int i = 0; i < 300 && !quiet; i++) begin
            @(negedge clk);
            if (!busy) begin
                quiet = 1;
                fall_cyc = cyc;
            end
        end
        chk("bridge_goes_idle", 32'(quiet), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    localparam line_t L_D  = 256'hD00D_0001_D00D_0002_D00D_0003_D00D_0004_D00D_0005_D00D_0006_D00D_0007_D00D_0008;
    localparam line_t L_W  = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam line_t L_W2 = 256'h0F0F_0F0F_1234_5678_0F0F_0F0F_9ABC_DEF0_0F0F_0F0F_1357_9BDF_0F0F_0F0F_2468_ACE0;
    localparam line_t L_W3 = 256'hAB;

    initial begin : main
        line_t rd;
        int    lat, c0, n0, n1, fall, qs, kind;
        logic [31:0] a;
        bit    seen;

        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        pm_resp_inject = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_resp", 32'(mem_resp), 32'd0);
        chk_line("reset_mem_rdata", mem_rdata, '0);
        chk("reset_pmem_read", 32'(pmem_read), 32'd0);
        chk("reset_pmem_write", 32'(pmem_write), 32'd0);
        chk("reset_pmem_address", pmem_address, 32'd0);
        chk_line("reset_pmem_wdata", pmem_wdata, '0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read miss with a 5-cycle pmem
        pm_mem[tag_of(32'h0000_1234)] = L_D;
        golden[tag_of(32'h0000_1234)] = L_D;
        fixed_delay = 5;
        c0 = cyc;
        do_req(1'b0, 1'b1, 32'h0000_1234, '0, rd, lat);
        chk("miss_pmem_address", last_pr_addr, 32'h0000_1220);
        chk("miss_pread_latency", 32'(pread_rise_cyc - c0), 32'd1);
        chk_line("miss_data", rd, L_D);
        chk("miss_resp_after_presp", 32'(mresp_cyc - presp_cyc), 32'd1);

        // Write then hit
        fixed_delay = 3;
        n0 = n_pwrite;
        n1 = n_pread;
        do_req(1'b1, 1'b0, 32'h0000_4000, L_W, rd, lat);
        chk("write_latency", 32'(lat), 32'd1);
        chk("write_no_pwrite_yet", 32'(n_pwrite - n0), 32'd0);
        do_req(1'b0, 1'b1, 32'h0000_401C, '0, rd, lat);
        chk("hit_latency", 32'(lat), 32'd1);
        chk_line("hit_data", rd, L_W);
        chk("hit_no_pread", 32'(n_pread - n1), 32'd0);

        // Background drain
        wait_quiet(fall);
        chk("drain_count", 32'(n_pwrite - n0), 32'd1);
        chk("drain_address", last_pw_addr, 32'h0000_4000);
        chk_line("drain_wdata", last_pw_data, L_W);
        chk("busy_drop_after_presp", 32'(fall - presp_cyc), 32'd1);
        chk_line("pmem_holds_line", pm_get(tag_of(32'h0000_4000)), L_W);

        // Full buffer: second write waits for the drain
        do_req(1'b1, 1'b0, 32'h0000_4000, L_W3, rd, lat);
        n0 = n_pwrite;
        do_req(1'b1, 1'b0, 32'h0000_8000, L_W2, rd, lat);
        chk("full_one_pwrite_before_resp", 32'(n_pwrite - n0), 32'd1);
        chk("full_drained_old_line", last_pw_addr, 32'h0000_4000);
        wait_quiet(fall);
        chk("full_second_drain_addr", last_pw_addr, 32'h0000_8000);
        chk_line("full_second_drain_data", last_pw_data, L_W2);

        // Read takes priority over the pending drain
        do_req(1'b1, 1'b0, 32'h0000_4000, L_W, rd, lat);
        qs = ev_wr.size();
        do_req(1'b0, 1'b1, 32'h0000_9000, '0, rd, lat);
        wait_quiet(fall);
        chk("prio_event_count", 32'(ev_wr.size() - qs), 32'd2);
        if (ev_wr.size() >= qs + 2) begin
            chk("prio_first_is_read", 32'(ev_wr[qs]), 32'd0);
            chk("prio_first_addr", ev_addr[qs], 32'h0000_9000);
            chk("prio_second_is_write", 32'(ev_wr[qs+1]), 32'd1);
            chk("prio_second_addr", ev_addr[qs+1], 32'h0000_4000);
        end

        // Reset in the middle of a pmem read
        fixed_delay = 20;
        mem_addr = 32'h0000_2000;
        mem_read = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        chk("rst_test_pread_seen", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pread_drops", 32'(pmem_read), 32'd0);
        chk("rst_mem_resp_low", 32'(mem_resp), 32'd0);
        mem_read = 1'b0;
        golden = pm_mem;
        pending.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fixed_delay = 0;
        pm_resp_inject = 1'b1;
        @(posedge clk);
        #1;
        pm_resp_inject = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_presp_busy", 32'(busy), 32'd0);
            chk("late_presp_mem_resp", 32'(mem_resp), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic over a small set of lines
        for (int n = 0; n < 250; n++) begin
            a = 32'h0001_0000 + ($urandom_range(0, 7) << OFFSET_BITS) + $urandom_range(0, 31);
            kind = $urandom_range(0, 9);
            if (kind < 5)      do_req(1'b0, 1'b1, a, '0, rd, lat);
            else if (kind < 9) do_req(1'b1, 1'b0, a, rand_line(), rd, lat);
            else               do_req(1'b1, 1'b1, a, rand_line(), rd, lat);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
            end
        end
        wait_quiet(fall);
        chk("final_nothing_pending", 32'(pending.num()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
